// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the data port,
// sequences the multi-cycle access and produces per-port stall signals.
module mem_port_arbiter #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned LAT  = 2,
  parameter int unsigned MAXD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          stall_if,
  output logic          stall_d,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned DCW = (MAXD > 0) ? $clog2(MAXD + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DCW-1:0]  dcnt, dcnt_nxt;
  logic            owner_d, owner_d_nxt;
  logic            en_nxt, we_nxt, if_ack_nxt, d_ack_nxt, d_err_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic            dreq;

  assign dreq     = d_read | d_write;
  assign stall_if = if_req & ~if_ack;
  assign stall_d  = dreq & ~d_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      owner_d   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dcnt      <= dcnt_nxt;
      owner_d   <= owner_d_nxt;
      mem_en    <= en_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ack    <= if_ack_nxt;
      d_ack     <= d_ack_nxt;
      d_err     <= d_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dcnt_nxt     = dcnt;
    owner_d_nxt  = owner_d;
    en_nxt       = mem_en;
    we_nxt       = mem_we;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    d_err_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        // Data wins unless fetch has already waited through MAXD data grants.
        if (dreq && !(if_req && dcnt == DCW'(MAXD))) begin
          state_nxt   = ACCESS;
          cnt_nxt     = CW'(LAT - 1);
          owner_d_nxt = 1'b1;
          en_nxt      = 1'b1;
          we_nxt      = d_write;
          addr_nxt    = d_addr;
          wdata_nxt   = d_wdata;
          d_err_nxt   = d_read & d_write;
          if (!if_req)                  dcnt_nxt = '0;
          else if (dcnt != DCW'(MAXD))  dcnt_nxt = dcnt + DCW'(1);
        end else if (if_req) begin
          state_nxt   = ACCESS;
          cnt_nxt     = CW'(LAT - 1);
          owner_d_nxt = 1'b0;
          en_nxt      = 1'b1;
          we_nxt      = 1'b0;
          addr_nxt    = if_addr;
          wdata_nxt   = '0;
          dcnt_nxt    = '0;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          en_nxt    = 1'b0;
          we_nxt    = 1'b0;
          if (owner_d) begin
            d_ack_nxt = 1'b1;
            if (!mem_we) d_rdata_nxt = mem_rdata;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_read, d_write;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_ack, d_ack, stall_if, stall_d, d_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      mem[16] <= 32'h8C22_0004;
      mem[64] <= 32'h0000_0055;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAXD(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_if(stall_if), .stall_d(stall_d), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string         name;
    logic          if_req;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    int            exp_we;
    int            exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the chosen ack, tallying memory activity along the way.
  task automatic wait_ack(input bit want_d, output int cyc, output int en_cnt,
                          output int we_cnt, output int err_cnt, output logic st1);
    cyc = 0; en_cnt = 0; we_cnt = 0; err_cnt = 0; st1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (d_err)  err_cnt++;
      if (cyc == 1) st1 = want_d ? stall_d : stall_if;
      if (want_d ? d_ack : if_ack) return;
    end
    cyc = -1;
  endtask

  function automatic vec_t mk(input string n, input logic f, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [DW-1:0] er, input int ewe, input int eerr);
    vec_t v;
    v.name = n; v.if_req = f; v.d_read = r; v.d_write = w; v.addr = a;
    v.wdata = wd; v.exp_rdata = er; v.exp_we = ewe; v.exp_err = eerr;
    return v;
  endfunction

  task automatic idle_inputs();
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    int cyc, en_cnt, we_cnt, err_cnt;
    logic st1;
    logic order [6];
    logic exp_order [6];

    vecs[0] = mk("fetch_0x40",  1'b1, 1'b0, 1'b0, 32'h40,  32'h0,          32'h8C22_0004, 0,   0);
    vecs[1] = mk("read_0x100",  1'b0, 1'b1, 1'b0, 32'h100, 32'h0,          32'h0000_0055, 0,   0);
    vecs[2] = mk("write_0x200", 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF,  32'h0000_0055, LAT, 0);
    vecs[3] = mk("read_0x200",  1'b0, 1'b1, 1'b0, 32'h200, 32'h0,          32'hDEAD_BEEF, 0,   0);
    vecs[4] = mk("rw_0x104",    1'b0, 1'b1, 1'b1, 32'h104, 32'h1234_5678,  32'hDEAD_BEEF, LAT, 1);
    vecs[5] = mk("read_0x104",  1'b0, 1'b1, 1'b0, 32'h104, 32'h0,          32'h1234_5678, 0,   0);

    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_mem_en",    32'(mem_en),   32'd0);
    check("rst_mem_we",    32'(mem_we),   32'd0);
    check("rst_if_ack",    32'(if_ack),   32'd0);
    check("rst_d_ack",     32'(d_ack),    32'd0);
    check("rst_d_err",     32'(d_err),    32'd0);
    check("rst_if_rdata",  if_rdata,      32'd0);
    check("rst_d_rdata",   d_rdata,       32'd0);
    check("rst_mem_addr",  mem_addr,      32'd0);
    check("rst_mem_wdata", mem_wdata,     32'd0);
    check("rst_stalls",    32'({stall_if, stall_d}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      if_req  = vecs[k].if_req;
      if_addr = vecs[k].addr;
      d_read  = vecs[k].d_read;
      d_write = vecs[k].d_write;
      d_addr  = vecs[k].addr;
      d_wdata = vecs[k].wdata;
      wait_ack(!vecs[k].if_req, cyc, en_cnt, we_cnt, err_cnt, st1);
      check({vecs[k].name, "_latency"}, 32'(cyc), 32'(LAT + 1));
      check({vecs[k].name, "_en_cycles"}, 32'(en_cnt), 32'(LAT));
      check({vecs[k].name, "_we_cycles"}, 32'(we_cnt), 32'(vecs[k].exp_we));
      check({vecs[k].name, "_err"}, 32'(err_cnt), 32'(vecs[k].exp_err));
      check({vecs[k].name, "_stall_first"}, 32'(st1), 32'd1);
      check({vecs[k].name, "_stall_at_ack"},
            32'(vecs[k].if_req ? stall_if : stall_d), 32'd0);
      check({vecs[k].name, "_rdata"},
            vecs[k].if_req ? if_rdata : d_rdata, vecs[k].exp_rdata);
      idle_inputs();
      @(negedge clk);
    end

    // Simultaneous fetch and data read: data first, fetch in the following idle cycle.
    if_req = 1'b1; if_addr = 32'h40; d_read = 1'b1; d_addr = 32'h100;
    wait_ack(1'b1, cyc, en_cnt, we_cnt, err_cnt, st1);
    check("both_d_latency", 32'(cyc), 32'(LAT + 1));
    check("both_d_rdata", d_rdata, 32'h55);
    check("both_no_if_ack_yet", 32'(if_ack), 32'd0);
    d_read = 1'b0;
    wait_ack(1'b0, cyc, en_cnt, we_cnt, err_cnt, st1);
    check("both_if_latency", 32'(cyc), 32'(LAT + 1));
    check("both_if_rdata", if_rdata, 32'h8C22_0004);
    idle_inputs();
    @(negedge clk);

    // Fairness: both held continuously, acks reveal the grant order.
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h40; d_read = 1'b1; d_addr = 32'h100;
    for (int g = 0; g < 6; g++) begin
      order[g] = 1'bx;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (d_ack || if_ack) begin
          order[g] = d_ack;
          break;
        end
      end
      check($sformatf("fair_grant_%0d", g), 32'(order[g]), 32'(exp_order[g]));
    end
    idle_inputs();
    @(negedge clk);

    // Reset in the final access cycle aborts the fetch; it is re-granted afterwards.
    if_req = 1'b1; if_addr = 32'h40;
    repeat (2) @(negedge clk);
    check("abort_in_access", 32'(mem_en), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_no_ack", 32'(if_ack), 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_stall_if", 32'(stall_if), 32'd1);
    @(negedge clk);
    check("abort_still_no_ack", 32'(if_ack | mem_en), 32'd0);
    rst = 1'b1;
    wait_ack(1'b0, cyc, en_cnt, we_cnt, err_cnt, st1);
    check("regrant_latency", 32'(cyc), 32'(LAT + 1));
    check("regrant_rdata", if_rdata, 32'h8C22_0004);
    idle_inputs();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
